mem_access_unit: RTL and testbench

Load/store initiator for the multicycle datapath's byte-addressed, 24-bit-word data memory. Accepts one load or store request at a time from the control unit, sequences memRd/memWr on the memory port, and handles the registered one-cycle read latency. Byte stores become read-modify-write sequences because the memory only writes full 3-byte words. Returns load data with a one-cycle done pulse.

---
 rtl/mau_pkg.sv | 19 +
 rtl/mau_byte_lane.sv | 23 ++
 rtl/mem_access_unit.sv | 121 ++++++++++++
 tb/tb_mem_access_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared types and constants for the memory access unit: FSM state codes,
// word geometry and the byte-lane position inside a 24-bit memory word.
package mau_pkg;

  localparam int WORD_W     = 24;
  localparam int WORD_BYTES = 3;
  localparam int BYTE_W     = 8;
  localparam int BYTE_MSB   = 23;
  localparam int BYTE_LSB   = 16;

  // State enumeration kept as plain localparam codes so older tools accept it.
  typedef logic [2:0] mau_state_t;
  localparam mau_state_t ST_IDLE = 3'd0;
  localparam mau_state_t ST_RD   = 3'd1;
  localparam mau_state_t ST_CAP  = 3'd2;
  localparam mau_state_t ST_WR   = 3'd3;
  localparam mau_state_t ST_RESP = 3'd4;

endpackage

// File: rtl/mau_byte_lane.sv
// Byte lane helper: extracts the addressed byte (MSB lane) of a word with
// optional sign extension, and merges a store byte into an existing word.
module mau_byte_lane
  import mau_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              signed_i,
  output logic [WORD_W-1:0] load_o,
  output logic [WORD_W-1:0] merge_o
);

  logic [BYTE_W-1:0] lane;
  logic              fill;

  assign lane = word_i[BYTE_MSB:BYTE_LSB];
  assign fill = signed_i & word_i[BYTE_MSB];

  assign load_o  = {{(WORD_W-BYTE_W){fill}}, lane};
  // The addressed byte is the MSB of the word, so the two bytes after it survive.
  assign merge_o = {byte_i, word_i[BYTE_LSB-1:0]};

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the 24-bit-word, byte-addressed data memory.
// Optional range checking is enabled by defining MAU_RANGE_CHECK_EN.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              reqWr,
  input  logic              reqByte,
  input  logic              reqSigned,
  input  logic [WORD_W-1:0] reqAddr,
  input  logic [WORD_W-1:0] reqData,
  output logic              ready,
  output logic              done,
  output logic [WORD_W-1:0] rdData,
  output logic              fault,
  output logic [WORD_W-1:0] memAddr,
  output logic [WORD_W-1:0] memWrData,
  output logic              memRd,
  output logic              memWr,
  input  logic [WORD_W-1:0] memRdData
);

`ifdef MAU_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  localparam logic [WORD_W-1:0] LAST_ADDR = WORD_W'(MEM_BYTES - WORD_BYTES);

  // Handshake: a request is taken on the rising edge where ready && req;
  // ready is high only in IDLE, and done pulses exactly once per taken request.
  mau_state_t state_q, state_d;

  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] data_q;
  logic              wr_q;
  logic              byte_q;
  logic              sgn_q;
  logic              fault_q;
  logic [WORD_W-1:0] wrbuf_q;
  logic [WORD_W-1:0] rd_data_q;

  logic              accept;
  logic              range_bad;
  logic [WORD_W-1:0] lane_load;
  logic [WORD_W-1:0] lane_merge;

  assign accept    = (state_q == ST_IDLE) && req;
  assign range_bad = RANGE_CHECK && (reqAddr > LAST_ADDR);

  mau_byte_lane u_byte_lane (
    .word_i   (memRdData),
    .byte_i   (data_q[BYTE_W-1:0]),
    .signed_i (sgn_q),
    .load_o   (lane_load),
    .merge_o  (lane_merge)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (range_bad)              state_d = ST_RESP;
          else if (reqWr && !reqByte) state_d = ST_WR;
          else                        state_d = ST_RD;
        end
      end
      ST_RD:   state_d = ST_CAP;
      ST_CAP:  state_d = wr_q ? ST_WR : ST_RESP;
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      byte_q    <= 1'b0;
      sgn_q     <= 1'b0;
      fault_q   <= 1'b0;
      wrbuf_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= reqAddr;
        data_q  <= reqData;
        wr_q    <= reqWr;
        byte_q  <= reqByte;
        sgn_q   <= reqSigned;
        fault_q <= range_bad;
      end
      if (state_q == ST_CAP) begin
        if (wr_q) wrbuf_q   <= lane_merge;
        else      rd_data_q <= byte_q ? lane_load : memRdData;
      end
    end
  end

  assign ready  = (state_q == ST_IDLE);
  assign done   = (state_q == ST_RESP);
  assign rdData = rd_data_q;
  assign fault  = RANGE_CHECK && fault_q && (state_q == ST_RESP);

  // Strobes are gated with rst so a reset landing mid-store never writes memory.
  assign memRd     = (state_q == ST_RD) && !rst;
  assign memWr     = (state_q == ST_WR) && !rst;
  assign memAddr   = ((state_q == ST_RD) || (state_q == ST_WR)) ? addr_q : '0;
  assign memWrData = (state_q == ST_WR) ? (byte_q ? wrbuf_q : data_q) : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level reference model checked every
// cycle, directed request sequences with hand-computed literal expectations.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, reqWr, reqByte, reqSigned;
  logic [23:0] reqAddr, reqData;
  logic        ready, done, fault, memRd, memWr;
  logic [23:0] rdData, memAddr, memWrData, memRdData;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_access_unit #(.MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst), .req(req), .reqWr(reqWr), .reqByte(reqByte),
    .reqSigned(reqSigned), .reqAddr(reqAddr), .reqData(reqData),
    .ready(ready), .done(done), .rdData(rdData), .fault(fault),
    .memAddr(memAddr), .memWrData(memWrData), .memRd(memRd), .memWr(memWr),
    .memRdData(memRdData)
  );

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory (DUT side) ----------------
  logic [7:0]  sim_mem [0:2047];
  logic [7:0]  ref_mem [0:2047];
  logic [23:0] mem_rd_q = '0;
  logic [10:0] sa;
  assign sa = memAddr[10:0];
  assign memRdData = mem_rd_q;

  always @(posedge clk) begin
    if (memWr) begin
      sim_mem[sa]         <= memWrData[23:16];
      sim_mem[sa + 11'd1] <= memWrData[15:8];
      sim_mem[sa + 11'd2] <= memWrData[7:0];
    end
    if (memRd) mem_rd_q <= {sim_mem[sa], sim_mem[sa + 11'd1], sim_mem[sa + 11'd2]};
  end

  // ---------------- reference model ----------------
  function automatic logic [23:0] ref_word(input logic [23:0] a);
    logic [10:0] i;
    i = a[10:0];
    return {ref_mem[i], ref_mem[i + 11'd1], ref_mem[i + 11'd2]};
  endfunction

  function automatic logic range_fault(input logic [23:0] a);
`ifdef MAU_RANGE_CHECK_EN
    return a > 24'd1021;
`else
    return 1'b0;
`endif
  endfunction

  // ph = cycle index since acceptance (0 = idle); lat/rd_ph/wr_ph are the
  // documented latencies of each access kind.
  int          ph = 0, m_lat = 0, m_rd_ph = 0, m_wr_ph = 0;
  logic        m_fault = 1'b0, m_load = 1'b0;
  logic [23:0] m_addr = '0, m_wdata = '0, m_lval = '0, m_rd = '0;

  always @(posedge clk) begin
    if (rst) begin
      ph = 0; m_rd = '0; m_fault = 1'b0;
    end else if (ph == 0) begin
      if (req) begin
        logic [23:0] w;
        w = ref_word(reqAddr);
        m_addr = reqAddr; m_fault = range_fault(reqAddr);
        m_load = !reqWr; m_rd_ph = 0; m_wr_ph = 0;
        if (m_fault) m_lat = 1;
        else if (reqWr && !reqByte) begin
          m_lat = 2; m_wr_ph = 1; m_wdata = reqData;
        end else if (reqWr) begin
          m_lat = 4; m_rd_ph = 1; m_wr_ph = 3; m_wdata = {reqData[7:0], w[15:0]};
        end else begin
          m_lat = 3; m_rd_ph = 1;
          if (!reqByte)       m_lval = w;
          else if (reqSigned) m_lval = {{16{w[23]}}, w[23:16]};
          else                m_lval = {16'h0000, w[23:16]};
        end
        ph = 1;
      end
    end else begin
      if (ph == m_wr_ph) begin
        ref_mem[m_addr[10:0]]         = m_wdata[23:16];
        ref_mem[m_addr[10:0] + 11'd1] = m_wdata[15:8];
        ref_mem[m_addr[10:0] + 11'd2] = m_wdata[7:0];
      end
      if (ph == m_lat) ph = 0;
      else             ph = ph + 1;
      if (ph != 0 && ph == m_lat && m_load && !m_fault) m_rd = m_lval;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic e_done, e_rd, e_wr;
    #3;
    if (rst) begin
      chk("memRd_in_rst", {23'd0, memRd}, 24'd0);
      chk("memWr_in_rst", {23'd0, memWr}, 24'd0);
    end else begin
      e_done = (ph != 0) && (ph == m_lat);
      e_rd   = (ph != 0) && (ph == m_rd_ph);
      e_wr   = (ph != 0) && (ph == m_wr_ph);
      chk("ready",     {23'd0, ready}, {23'd0, ph == 0});
      chk("done",      {23'd0, done},  {23'd0, e_done});
      chk("fault",     {23'd0, fault}, {23'd0, e_done && m_fault});
      chk("rdData",    rdData, m_rd);
      chk("memRd",     {23'd0, memRd}, {23'd0, e_rd});
      chk("memWr",     {23'd0, memWr}, {23'd0, e_wr});
      chk("memAddr",   memAddr,   (e_rd || e_wr) ? m_addr : 24'd0);
      chk("memWrData", memWrData, e_wr ? m_wdata : 24'd0);
    end
  end

  // ---------------- driver tasks ----------------
  int          t_lat, t_nrd, t_nwr, t_wrcyc;
  logic        t_flt;
  logic [23:0] t_rd, t_wdata;

  task automatic wait_ready();
    for (int k = 0; k < 20; k++) begin
      if (ready) return;
      @(negedge clk);
    end
    chk("ready_timeout", {23'd0, ready}, 24'd1);
  endtask

  task automatic issue(input logic wr, input logic byt, input logic sgn,
                       input logic [23:0] a, input logic [23:0] d);
    wait_ready();
    req = 1'b1; reqWr = wr; reqByte = byt; reqSigned = sgn; reqAddr = a; reqData = d;
    @(negedge clk);
    req = 1'b0;
    t_lat = 0; t_nrd = 0; t_nwr = 0; t_wrcyc = 0; t_wdata = '0; t_rd = '0; t_flt = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (memRd) t_nrd++;
      if (memWr) begin
        t_nwr++; t_wdata = memWrData;
        if (t_wrcyc == 0) t_wrcyc = k;
      end
      if (done) begin
        t_lat = k; t_rd = rdData; t_flt = fault;
        break;
      end
      @(negedge clk);
    end
    if (t_lat == 0) chk("done_timeout", 24'd0, 24'd1);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ndone;
    for (int i = 0; i < 2048; i++) begin
      sim_mem[i] = 8'h00; ref_mem[i] = 8'h00;
    end
    sim_mem[11'h020] = 8'hC0; sim_mem[11'h021] = 8'hFF; sim_mem[11'h022] = 8'hEE;
    sim_mem[11'h040] = 8'h0A; sim_mem[11'h041] = 8'h0B; sim_mem[11'h042] = 8'h0C;
    sim_mem[11'h3FD] = 8'h11; sim_mem[11'h3FE] = 8'h22; sim_mem[11'h3FF] = 8'h33;
    sim_mem[11'h400] = 8'h44;
    for (int i = 0; i < 2048; i++) ref_mem[i] = sim_mem[i];

    rst = 1'b1; req = 1'b0; reqWr = 1'b0; reqByte = 1'b0; reqSigned = 1'b0;
    reqAddr = '0; reqData = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready",  {23'd0, ready}, 24'd1);
    chk("rst_rdData", rdData, 24'd0);
    chk("rst_memAddr", memAddr, 24'd0);

    // word store then word load
    issue(1'b1, 1'b0, 1'b0, 24'h000012, 24'hA1B2C3);
    chk("wst_lat", 24'(t_lat), 24'd2);
    chk("wst_wrcyc", 24'(t_wrcyc), 24'd1);
    issue(1'b0, 1'b0, 1'b0, 24'h000012, 24'h0);
    chk("wld_lat", 24'(t_lat), 24'd3);
    chk("wld_data", t_rd, 24'hA1B2C3);

    // byte store read-modify-write
    issue(1'b1, 1'b1, 1'b0, 24'h000012, 24'h00005A);
    chk("bst_lat", 24'(t_lat), 24'd4);
    chk("bst_nrd", 24'(t_nrd), 24'd1);
    chk("bst_nwr", 24'(t_nwr), 24'd1);
    chk("bst_wdata", t_wdata, 24'h5AB2C3);
    issue(1'b0, 1'b0, 1'b0, 24'h000012, 24'h0);
    chk("bst_readback", t_rd, 24'h5AB2C3);

    // byte loads, signed and unsigned
    issue(1'b1, 1'b1, 1'b0, 24'h000012, 24'hFFFF9C);
    issue(1'b0, 1'b1, 1'b1, 24'h000012, 24'h0);
    chk("bld_signed", t_rd, 24'hFFFF9C);
    issue(1'b0, 1'b1, 1'b0, 24'h000012, 24'h0);
    chk("bld_unsigned", t_rd, 24'h00009C);

    // extra req held during RD/CAP/WR of a byte store
    wait_ready();
    req = 1'b1; reqWr = 1'b1; reqByte = 1'b1; reqAddr = 24'h000020; reqData = 24'h000077;
    @(negedge clk);
    reqByte = 1'b0; reqAddr = 24'h000030; reqData = 24'h111111;
    ndone = 0;
    for (int k = 1; k <= 8; k++) begin
      if (done) ndone++;
      if (k == 4) req = 1'b0;
      @(negedge clk);
    end
    chk("busy_done_cnt", 24'(ndone), 24'd1);
    issue(1'b0, 1'b0, 1'b0, 24'h000020, 24'h0);
    chk("busy_mem20", t_rd, 24'h77FFEE);
    issue(1'b0, 1'b0, 1'b0, 24'h000030, 24'h0);
    chk("busy_mem30", t_rd, 24'h000000);

    // reset in the WR cycle of a word store
    wait_ready();
    req = 1'b1; reqWr = 1'b1; reqByte = 1'b0; reqAddr = 24'h000040; reqData = 24'h123456;
    @(negedge clk);
    req = 1'b0; rst = 1'b1;
    #1 chk("rstwr_memWr", {23'd0, memWr}, 24'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rstwr_ready", {23'd0, ready}, 24'd1);
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("rstwr_no_done", 24'(ndone), 24'd0);
    issue(1'b0, 1'b0, 1'b0, 24'h000040, 24'h0);
    chk("rstwr_mem40", t_rd, 24'h0A0B0C);

    // top of memory
    issue(1'b0, 1'b0, 1'b0, 24'h0003FE, 24'h0);
`ifdef MAU_RANGE_CHECK_EN
    chk("rng_lat", 24'(t_lat), 24'd1);
    chk("rng_fault", {23'd0, t_flt}, 24'd1);
    chk("rng_nrd", 24'(t_nrd), 24'd0);
    chk("rng_rd_hold", t_rd, 24'h0A0B0C);
`else
    chk("nrng_lat", 24'(t_lat), 24'd3);
    chk("nrng_data", t_rd, 24'h223344);
`endif
    issue(1'b0, 1'b0, 1'b0, 24'h0003FD, 24'h0);
    chk("edge_lat", 24'(t_lat), 24'd3);
    chk("edge_fault", {23'd0, t_flt}, 24'd0);
    chk("edge_data", t_rd, 24'h112233);

    repeat (3) @(negedge clk);
    ndone = 0;
    for (int i = 0; i < 2048; i++) if (sim_mem[i] !== ref_mem[i]) ndone++;
    chk("mem_image_diffs", 24'(ndone), 24'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
